cfg_reg_slave: RTL and testbench

- Synthesizable AXI4-style configuration register target with single ID, one outstanding transaction per direction.
- Responder side of the 64-bit packed write (aw/w/b) and read (ar/r) channels that the DMA's config port and the bench drive as initiators.
- Holds NUM_REGS 64-bit control registers at ADDR_STRIDE spacing.
- Exposes register contents and per-register write pulses to downstream datapath logic.

---
 rtl/cfg_reg_slave_if.sv | 36 +++
 rtl/cfg_reg_slave.sv | 219 +++++++++++++++++++++
 tb/tb_cfg_reg_slave.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_reg_slave_if.sv
// Packed AXI4-style config bus: aw/w/b write channels and ar/r read channels.
// Pure wiring, no latency.
// Backpressure is carried by the *_vld/*_rdy pairs of each channel.
interface cfg_reg_slave_if;
  logic [43:0] w_slave0_aw_dat;
  logic        w_slave0_aw_vld;
  logic        w_slave0_aw_rdy;
  logic [72:0] w_slave0_w_dat;
  logic        w_slave0_w_vld;
  logic        w_slave0_w_rdy;
  logic [5:0]  w_slave0_b_dat;
  logic        w_slave0_b_vld;
  logic        w_slave0_b_rdy;
  logic [43:0] r_slave0_ar_dat;
  logic        r_slave0_ar_vld;
  logic        r_slave0_ar_rdy;
  logic [70:0] r_slave0_r_dat;
  logic        r_slave0_r_vld;
  logic        r_slave0_r_rdy;

  modport master (
    output w_slave0_aw_dat, w_slave0_aw_vld, input w_slave0_aw_rdy,
    output w_slave0_w_dat,  w_slave0_w_vld,  input w_slave0_w_rdy,
    input  w_slave0_b_dat,  w_slave0_b_vld,  output w_slave0_b_rdy,
    output r_slave0_ar_dat, r_slave0_ar_vld, input r_slave0_ar_rdy,
    input  r_slave0_r_dat,  r_slave0_r_vld,  output r_slave0_r_rdy
  );

  modport slave (
    input  w_slave0_aw_dat, w_slave0_aw_vld, output w_slave0_aw_rdy,
    input  w_slave0_w_dat,  w_slave0_w_vld,  output w_slave0_w_rdy,
    output w_slave0_b_dat,  w_slave0_b_vld,  input w_slave0_b_rdy,
    input  r_slave0_ar_dat, r_slave0_ar_vld, output r_slave0_ar_rdy,
    output r_slave0_r_dat,  r_slave0_r_vld,  input r_slave0_r_rdy
  );
endinterface

// File: rtl/cfg_reg_slave.sv
// Config register target: NUM_REGS x 64-bit regs behind an AXI4-style single-ID port; CFG_REG_WSTRB_EN enables byte strobes.
// Latency: 3 cycles per single-beat write (aw, w, b); read data 1 cycle after ar handshake.
// Backpressure: b_rdy/r_rdy low stalls the owning FSM indefinitely; the other direction keeps running.
module cfg_reg_slave #(
  parameter int          NUM_REGS        = 4,
  parameter int          ADDR_STRIDE_LG2 = 7,
  parameter logic [31:0] BASE_ADDR       = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_bar,
  cfg_reg_slave_if.slave         bus,
  output logic [NUM_REGS*64-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]    cfg_wr_pulse
);

  localparam int          IDXW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] OFF_MASK = (32'd1 << ADDR_STRIDE_LG2) - 32'd1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // A hit needs a stride-aligned offset that lands inside the register file.
  function automatic logic dec_hit(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return ((off & OFF_MASK) == 32'd0) && ((off >> ADDR_STRIDE_LG2) < 32'(NUM_REGS));
  endfunction

  function automatic logic [IDXW-1:0] dec_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDXW'(off >> ADDR_STRIDE_LG2);
  endfunction

  // Channel field breakout
  logic [31:0] w_aw_addr, w_ar_addr;
  logic [3:0]  w_aw_id,   w_ar_id;
  logic [7:0]  w_aw_len,  w_ar_len;
  logic [63:0] w_w_data;
  logic        w_w_last;
  logic [7:0]  w_w_strb, w_lane_en;

  assign w_aw_addr = bus.w_slave0_aw_dat[31:0];
  assign w_aw_id   = bus.w_slave0_aw_dat[35:32];
  assign w_aw_len  = bus.w_slave0_aw_dat[43:36];
  assign w_ar_addr = bus.r_slave0_ar_dat[31:0];
  assign w_ar_id   = bus.r_slave0_ar_dat[35:32];
  assign w_ar_len  = bus.r_slave0_ar_dat[43:36];
  assign w_w_data  = bus.w_slave0_w_dat[63:0];
  assign w_w_last  = bus.w_slave0_w_dat[64];
  assign w_w_strb  = bus.w_slave0_w_dat[72:65];

`ifdef CFG_REG_WSTRB_EN
  assign w_lane_en = w_w_strb;
`else
  // Strobes are saturated: every accepted beat writes all eight lanes.
  assign w_lane_en = w_w_strb | 8'hFF;
`endif

  // Registered handshake outputs and write context
  wstate_t             r_wstate, w_wstate_nxt;
  logic                r_aw_rdy, r_w_rdy, r_b_vld;
  logic [5:0]          r_b_dat;
  logic [IDXW-1:0]     r_widx;
  logic                r_whit, r_werr;
  logic [3:0]          r_wid;
  logic [7:0]          r_wcnt;

  rstate_t             r_rstate, w_rstate_nxt;
  logic                r_ar_rdy, r_r_vld;
  logic [70:0]         r_r_dat;
  logic [IDXW-1:0]     r_ridx;
  logic                r_rhit;
  logic [3:0]          r_rid;
  logic [7:0]          r_rcnt;

  logic [63:0]         r_regs     [NUM_REGS];
  logic [63:0]         w_regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse, w_pulse_nxt;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_w_final, w_last_bad, w_r_final;
  logic w_ar_hit;
  logic [IDXW-1:0] w_ar_idx;

  assign w_aw_hs    = bus.w_slave0_aw_vld & r_aw_rdy;
  assign w_w_hs     = bus.w_slave0_w_vld  & r_w_rdy;
  assign w_b_hs     = r_b_vld & bus.w_slave0_b_rdy;
  assign w_ar_hs    = bus.r_slave0_ar_vld & r_ar_rdy;
  assign w_r_hs     = r_r_vld & bus.r_slave0_r_rdy;
  // The beat count alone ends a burst; a disagreeing last bit only poisons the response.
  assign w_w_final  = (r_wcnt == 8'd0);
  assign w_last_bad = w_w_hs & (w_w_last != w_w_final);
  assign w_r_final  = (r_rcnt == 8'd0);
  assign w_ar_hit   = dec_hit(w_ar_addr);
  assign w_ar_idx   = dec_idx(w_ar_addr);

  // Write FSM next state
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs)               w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_w_final)   w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs)                w_wstate_nxt = W_IDLE;
      default:                            w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state, registered channel controls and per-transaction context
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      r_wstate <= W_IDLE;
      r_aw_rdy <= 1'b1;
      r_w_rdy  <= 1'b0;
      r_b_vld  <= 1'b0;
      r_b_dat  <= '0;
      r_widx   <= '0;
      r_whit   <= 1'b0;
      r_werr   <= 1'b0;
      r_wid    <= '0;
      r_wcnt   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_aw_rdy <= (w_wstate_nxt == W_IDLE);
      r_w_rdy  <= (w_wstate_nxt == W_DATA);
      r_b_vld  <= (w_wstate_nxt == W_RESP);
      if (w_aw_hs) begin
        r_widx <= dec_idx(w_aw_addr);
        r_whit <= dec_hit(w_aw_addr);
        r_wid  <= w_aw_id;
        r_wcnt <= w_aw_len;
        r_werr <= 1'b0;
      end
      if (w_w_hs) begin
        if (!w_w_final) r_wcnt <= r_wcnt - 8'd1;
        if (w_last_bad) r_werr <= 1'b1;
        if (w_w_final)
          r_b_dat <= {r_wid, (r_whit && !r_werr && !w_last_bad) ? 2'b00 : 2'b10};
      end
    end
  end

  // Next register contents: FIXED burst, every beat lands on the latched index
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) w_regs_nxt[i] = r_regs[i];
    w_pulse_nxt = '0;
    if (w_w_hs && r_whit) begin
      for (int k = 0; k < 8; k++)
        if (w_lane_en[k]) w_regs_nxt[r_widx][8*k +: 8] = w_w_data[8*k +: 8];
      w_pulse_nxt[r_widx] = 1'b1;
    end
  end

  // Register file and write pulses; reset also wipes any partial burst
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= w_regs_nxt[i];
      r_wr_pulse <= w_pulse_nxt;
    end
  end

  // Read FSM next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)             w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && w_r_final) w_rstate_nxt = R_IDLE;
      default:                          w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state and beat loading; sampling the next-state register value
  // makes a same-edge write show up in the following beat, never the held one
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      r_rstate <= R_IDLE;
      r_ar_rdy <= 1'b1;
      r_r_vld  <= 1'b0;
      r_r_dat  <= '0;
      r_ridx   <= '0;
      r_rhit   <= 1'b0;
      r_rid    <= '0;
      r_rcnt   <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_ar_rdy <= (w_rstate_nxt == R_IDLE);
      r_r_vld  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_ridx  <= w_ar_idx;
        r_rhit  <= w_ar_hit;
        r_rid   <= w_ar_id;
        r_rcnt  <= w_ar_len;
        r_r_dat <= {w_ar_id, w_ar_hit ? 2'b00 : 2'b10, (w_ar_len == 8'd0),
                    w_ar_hit ? w_regs_nxt[w_ar_idx] : 64'd0};
      end else if (w_r_hs && !w_r_final) begin
        r_rcnt  <= r_rcnt - 8'd1;
        r_r_dat <= {r_rid, r_rhit ? 2'b00 : 2'b10, (r_rcnt == 8'd1),
                    r_rhit ? w_regs_nxt[r_ridx] : 64'd0};
      end
    end
  end

  assign bus.w_slave0_aw_rdy = r_aw_rdy;
  assign bus.w_slave0_w_rdy  = r_w_rdy;
  assign bus.w_slave0_b_vld  = r_b_vld;
  assign bus.w_slave0_b_dat  = r_b_dat;
  assign bus.r_slave0_ar_rdy = r_ar_rdy;
  assign bus.r_slave0_r_vld  = r_r_vld;
  assign bus.r_slave0_r_dat  = r_r_dat;
  assign cfg_wr_pulse        = r_wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign cfg_regs[64*g +: 64] = r_regs[g];
  end

endmodule

// File: tb/tb_cfg_reg_slave.sv
// Bench for cfg_reg_slave: scoreboarded b/r responses, register and pulse model.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Exercises write/read stalls, decode misses, burst reads with a concurrent write and mid-burst reset.
module tb_cfg_reg_slave;
  typedef logic [255:0] v_t;

`ifdef CFG_REG_WSTRB_EN
  localparam bit WSTRB_ON = 1'b1;
`else
  localparam bit WSTRB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_bar = 1'b0;
  logic [255:0] cfg_regs;
  logic [3:0]  cfg_wr_pulse;

  cfg_reg_slave_if bus();

  cfg_reg_slave dut (
    .clk          (clk),
    .rst_bar      (rst_bar),
    .bus          (bus),
    .cfg_regs     (cfg_regs),
    .cfg_wr_pulse (cfg_wr_pulse)
  );

  always #5 clk = ~clk;

  logic [5:0]  b_q [$];
  logic [70:0] r_q [$];
  logic [63:0] m_regs [4];
  int          pulse_cnt [4];
  int          exp_pulse [4];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input v_t act, input v_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic v_t model_vec();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++)
      if (!WSTRB_ON || s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Output monitor: handshakes are predicted at the falling edge before the accepting rising edge
  always @(negedge clk) begin
    logic [5:0]  eb;
    logic [70:0] er;
    if (rst_bar) begin
      for (int i = 0; i < 4; i++) if (cfg_wr_pulse[i]) pulse_cnt[i]++;
      if (bus.w_slave0_b_vld && bus.w_slave0_b_rdy) begin
        if (b_q.size() == 0) check("b_extra", v_t'(b_q.size()), v_t'(1));
        else begin
          eb = b_q.pop_front();
          check("b_dat", v_t'(bus.w_slave0_b_dat), v_t'(eb));
        end
      end
      if (bus.r_slave0_r_vld && bus.r_slave0_r_rdy) begin
        if (r_q.size() == 0) check("r_extra", v_t'(r_q.size()), v_t'(1));
        else begin
          er = r_q.pop_front();
          check("r_dat", v_t'(bus.r_slave0_r_dat), v_t'(er));
        end
      end
    end
  end

  // Handshake helpers: entered and left 1 unit after a rising edge
  task automatic send_aw(input logic [43:0] d);
    int n = 0;
    bus.w_slave0_aw_dat = d;
    bus.w_slave0_aw_vld = 1'b1;
    @(negedge clk);
    while (!bus.w_slave0_aw_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("aw_timeout", v_t'(bus.w_slave0_aw_rdy), v_t'(1));
    @(posedge clk); #1;
    bus.w_slave0_aw_vld = 1'b0;
  endtask

  task automatic send_w(input logic [72:0] d);
    int n = 0;
    bus.w_slave0_w_dat = d;
    bus.w_slave0_w_vld = 1'b1;
    @(negedge clk);
    while (!bus.w_slave0_w_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("w_timeout", v_t'(bus.w_slave0_w_rdy), v_t'(1));
    @(posedge clk); #1;
    bus.w_slave0_w_vld = 1'b0;
  endtask

  task automatic send_ar(input logic [43:0] d);
    int n = 0;
    bus.r_slave0_ar_dat = d;
    bus.r_slave0_ar_vld = 1'b1;
    @(negedge clk);
    while (!bus.r_slave0_ar_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("ar_timeout", v_t'(bus.r_slave0_ar_rdy), v_t'(1));
    @(posedge clk); #1;
    bus.r_slave0_ar_vld = 1'b0;
  endtask

  task automatic wait_b_drain();
    int n = 0;
    while (b_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("b_timeout", v_t'(b_q.size()), v_t'(0));
    @(posedge clk); #1;
  endtask

  task automatic wait_r_drain();
    int n = 0;
    while (r_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("r_timeout", v_t'(r_q.size()), v_t'(0));
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] id, input int len,
                    input logic [63:0] data, input logic [7:0] strb,
                    input bit bad_last, input int bstall);
    int   idx;
    logic hit;
    logic last;
    idx = int'(addr >> 7);
    hit = (addr[6:0] == 7'd0) && (addr < 32'h200);
    b_q.push_back({id, (hit && !bad_last) ? 2'b00 : 2'b10});
    bus.w_slave0_b_rdy = (bstall == 0);
    send_aw({8'(len), id, addr});
    @(negedge clk);
    check("w_rdy_lat", v_t'(bus.w_slave0_w_rdy), v_t'(1));
    @(posedge clk); #1;
    for (int b = 0; b <= len; b++) begin
      last = (b == len) ^ bad_last;
      send_w({strb, last, data});
      if (hit) begin
        m_regs[idx] = merge(m_regs[idx], data, strb);
        exp_pulse[idx]++;
      end
    end
    @(negedge clk);
    check("b_vld_lat", v_t'(bus.w_slave0_b_vld), v_t'(1));
    check("regs_at_b", cfg_regs, model_vec());
    if (bstall > 0) begin
      repeat (bstall) @(negedge clk);
      check("b_hold", v_t'(bus.w_slave0_b_vld), v_t'(1));
      @(posedge clk); #1;
      bus.w_slave0_b_rdy = 1'b1;
    end
    wait_b_drain();
  endtask

  task automatic rd(input logic [31:0] addr, input logic [3:0] id, input int len);
    int   idx;
    logic hit;
    idx = int'(addr >> 7);
    hit = (addr[6:0] == 7'd0) && (addr < 32'h200);
    for (int b = 0; b <= len; b++)
      r_q.push_back({id, hit ? 2'b00 : 2'b10, b == len, hit ? m_regs[idx] : 64'd0});
    send_ar({8'(len), id, addr});
    @(negedge clk);
    check("r_vld_lat", v_t'(bus.r_slave0_r_vld), v_t'(1));
    @(posedge clk); #1;
    wait_r_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bus.w_slave0_aw_dat = '0; bus.w_slave0_aw_vld = 1'b0;
    bus.w_slave0_w_dat  = '0; bus.w_slave0_w_vld  = 1'b0;
    bus.w_slave0_b_rdy  = 1'b1;
    bus.r_slave0_ar_dat = '0; bus.r_slave0_ar_vld = 1'b0;
    bus.r_slave0_r_rdy  = 1'b1;
    for (int i = 0; i < 4; i++) begin m_regs[i] = '0; pulse_cnt[i] = 0; exp_pulse[i] = 0; end

    // Reset state
    @(negedge clk);
    check("rst_aw_rdy", v_t'(bus.w_slave0_aw_rdy), v_t'(1));
    check("rst_ar_rdy", v_t'(bus.r_slave0_ar_rdy), v_t'(1));
    check("rst_w_rdy",  v_t'(bus.w_slave0_w_rdy),  v_t'(0));
    check("rst_b_vld",  v_t'(bus.w_slave0_b_vld),  v_t'(0));
    check("rst_r_vld",  v_t'(bus.r_slave0_r_vld),  v_t'(0));
    check("rst_b_dat",  v_t'(bus.w_slave0_b_dat),  v_t'(0));
    check("rst_r_dat",  v_t'(bus.r_slave0_r_dat),  v_t'(0));
    check("rst_regs",   cfg_regs,                  v_t'(0));
    check("rst_pulse",  v_t'(cfg_wr_pulse),        v_t'(0));
    repeat (2) @(posedge clk);
    #1 rst_bar = 1'b1;
    @(posedge clk); #1;

    // One write per register, last with zero strobe
    wr(32'h000, 4'd0, 0, 64'h1000, 8'hFF, 1'b0, 0);
    wr(32'h080, 4'd0, 0, 64'h4000, 8'hFF, 1'b0, 0);
    wr(32'h100, 4'd0, 0, 64'h3F,   8'hFF, 1'b0, 0);
    wr(32'h180, 4'd0, 0, 64'h1,    8'h00, 1'b0, 0);
`ifdef CFG_REG_WSTRB_EN
    check("t1_regs", cfg_regs, {64'h0, 64'h3F, 64'h4000, 64'h1000});
`else
    check("t1_regs", cfg_regs, {64'h1, 64'h3F, 64'h4000, 64'h1000});
`endif
    for (int i = 0; i < 4; i++) check($sformatf("t1_pulse%0d", i), v_t'(pulse_cnt[i]), v_t'(1));

    // Single read with a non-zero id
    rd(32'h100, 4'd5, 0);

    // Decode misses: out of range and misaligned
    wr(32'h200, 4'd6, 0, 64'hDEAD, 8'hFF, 1'b0, 0);
    wr(32'h040, 4'd7, 0, 64'hBEEF, 8'hFF, 1'b0, 0);
    rd(32'h200, 4'd1, 0);

    // Last bit disagreeing with the beat count
    wr(32'h180, 4'd9, 1, 64'h77, 8'hFF, 1'b1, 0);

    // Write response stalled
    wr(32'h000, 4'd4, 0, 64'h2000, 8'hFF, 1'b0, 5);

    // Read burst stalled while the same register is rewritten
    bus.r_slave0_r_rdy = 1'b0;
    r_q.push_back({4'd3, 2'b00, 1'b0, m_regs[1]});
    send_ar({8'd2, 4'd3, 32'h80});
    @(negedge clk);
    check("burst_r_vld", v_t'(bus.r_slave0_r_vld), v_t'(1));
    @(posedge clk); #1;
    wr(32'h080, 4'd1, 0, 64'hAA, 8'hFF, 1'b0, 0);
    r_q.push_back({4'd3, 2'b00, 1'b0, m_regs[1]});
    r_q.push_back({4'd3, 2'b00, 1'b1, m_regs[1]});
    n = 0;
    while (r_q.size() != 0 && n < 40) begin
      bus.r_slave0_r_rdy = ~bus.r_slave0_r_rdy;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check("burst_timeout", v_t'(r_q.size()), v_t'(0));
    bus.r_slave0_r_rdy = 1'b1;
    repeat (4) @(negedge clk);
    check("burst_idle", v_t'(bus.r_slave0_r_vld), v_t'(0));
    @(posedge clk); #1;

`ifdef CFG_REG_WSTRB_EN
    // Partial-lane write
    wr(32'h000, 4'd2, 0, 64'h1122334455667788, 8'hFF, 1'b0, 0);
    wr(32'h000, 4'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 0);
    check("strb_reg0", v_t'(cfg_regs[63:0]), v_t'(64'h11223344FFFFFFFF));
`endif

    // Reset in the middle of a four-beat write
    send_aw({8'd3, 4'd2, 32'h0});
    send_w({8'hFF, 1'b0, 64'hDEAD});
    send_w({8'hFF, 1'b0, 64'hBEEF});
    exp_pulse[0] += 2;
    @(negedge clk);
    @(posedge clk); #1;
    rst_bar = 1'b0;
    @(negedge clk);
    check("mid_rst_regs",   cfg_regs,                  v_t'(0));
    check("mid_rst_b_vld",  v_t'(bus.w_slave0_b_vld),  v_t'(0));
    check("mid_rst_aw_rdy", v_t'(bus.w_slave0_aw_rdy), v_t'(1));
    repeat (2) @(posedge clk);
    #1 rst_bar = 1'b1;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    repeat (3) @(negedge clk);
    check("post_rst_b_vld",  v_t'(bus.w_slave0_b_vld),  v_t'(0));
    check("post_rst_aw_rdy", v_t'(bus.w_slave0_aw_rdy), v_t'(1));
    @(posedge clk); #1;
    wr(32'h100, 4'd7, 0, 64'h55, 8'hFF, 1'b0, 0);
    check("post_rst_regs", cfg_regs, {64'h0, 64'h55, 64'h0, 64'h0});

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("pulse_total%0d", i), v_t'(pulse_cnt[i]), v_t'(exp_pulse[i]));
    check("b_q_left", v_t'(b_q.size()), v_t'(0));
    check("r_q_left", v_t'(r_q.size()), v_t'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
